spi_mem_ctrl: RTL
=================

# spi_mem_ctrl

SPI slave front-end that sequences the 256×8 SPI memory. It samples the external SPI pins in the `clk` domain, decodes a command/address/data byte protocol, and drives the memory's write strobe, address and write-data. It also shifts read data back out on MISO. It sits between the chip pins and the memory instance and is the memory's only master.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `sclk`, `cs_n` and `mosi`; minimum 2.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `cs_n` in 1: SPI chip select, active-low, asynchronous to `clk`.
- `sclk` in 1: SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to `clk`, frequency ≤ clk/8.
- `mosi` in 1: serial data in, MSB first.
- `miso` out 1: serial data out, MSB first; 0 when not in a read data phase.
- `mem_wr` out 1: memory write strobe, one `clk` cycle per written byte.
- `mem_addr` out 8: memory address.
- `mem_din` out 8: memory write data.
- `mem_dout` in 8: memory combinational read data for `mem_addr`.
- `busy` out 1: high while a frame is active (synchronized `cs_n` low).
- `err` out 1: one-cycle pulse on an unknown command byte.

## Operation
- Frame format: CMD byte, ADDR byte, then 1..N data bytes, all MSB first. The frame ends when `cs_n` rises.
- Command values:
  - CMD_WRITE = 8'h02: data bytes go from MOSI into memory.
  - CMD_READ = 8'h03: data bytes go from memory out on MISO.
  - Any other value: ignored for the rest of the frame, with `err` pulsed.
- Edge detection: rising and falling `sclk` edges are detected on the synchronized signal. MOSI is sampled on the rising edge; MISO changes on the falling edge.
- Bit counter: 3 bits, cleared on frame start, incremented per rising edge. A byte completes when the counter wraps from 7 to 0.
- FSM states and transitions:
  - IDLE → CMD on synchronized `cs_n` falling.
  - CMD → WR_ADDR or RD_ADDR when a byte completes with a valid command.
  - CMD → IGNORE when the command is invalid.
  - WR_ADDR → WR_DATA; RD_ADDR → RD_DATA.
  - WR_DATA and RD_DATA loop on themselves.
  - Any state → IDLE when synchronized `cs_n` is high.
- Address byte complete: `mem_addr` is loaded with the received byte.
- Write data byte complete: `mem_din` gets the byte and `mem_wr` pulses for one cycle. On the next cycle `mem_addr` increments, wrapping 8'hFF → 8'h00.
- Read: the TX shift register loads `mem_dout` one cycle after `mem_addr` is valid, i.e. after the address byte, then again after each data byte.
  - `miso` = TX register bit 7 while in RD_DATA, else 0.
  - On each falling edge with bit counter ≠ 0, the TX register shifts left.
  - On completion of each read data byte, `mem_addr` increments (with wrap) and the register reloads. This gives a burst read.
- Aborts:
  - `cs_n` rising mid-byte discards the partial byte: no `mem_wr`, no address change.
  - `cs_n` rising in CMD/ADDR leaves memory untouched.
- Reset mid-frame: all state returns to the reset values below. The remainder of that frame is ignored until `cs_n` goes high and then low again.

## Timing
- Reset values: `miso`=0, `mem_wr`=0, `mem_addr`=0, `mem_din`=0, `busy`=0, `err`=0; FSM=IDLE; counters and shift registers 0.
- Input latency: SYNC_STAGES cycles to synchronize, plus 1 cycle for edge detect.
- `mem_wr` asserts exactly 1 cycle after the detected 8th rising edge of a data byte.
- `mem_addr`/`mem_din` are stable during the `mem_wr` cycle; `mem_addr` changes only on the cycle after it.
- `err` pulses 1 cycle after the 8th rising edge of an invalid CMD byte.
- The first MISO bit is valid no later than SYNC_STAGES+3 cycles after the address byte's 8th rising edge. This is guaranteed before the next rising edge by the clk/8 limit.
- `busy` follows synchronized `cs_n` with SYNC_STAGES latency.
- Simultaneous `cs_n` rise and byte completion: `cs_n` wins, so no write occurs.

## Structure
- Package `spi_pkg`: state enum `spi_state_t` (IDLE, CMD, WR_ADDR, RD_ADDR, WR_DATA, RD_DATA, IGNORE), plus constants CMD_WRITE and CMD_READ.
- Sub-module `spi_sync_edge`: parameterized synchronizer and edge detector for one bit. Outputs the synchronized level, a rise pulse and a fall pulse. Instantiated for `sclk` and `cs_n`; plain synchronizer for `mosi`.
- The FSM, counters and shift registers live in `spi_mem_ctrl`.

## Test plan
- Write frame 02,10,A5 → one `mem_wr` with `mem_addr`=8'h10 and `mem_din`=8'hA5. Then frame 03,10,xx → MISO returns 8'hA5.
- Burst write 02,FF,11,22 → writes 8'hFF=11 then 8'h00=22, confirming wrap. Burst read 03,FF → returns 11, 22.
- Invalid command 9F,10,55 → `err` pulses once; no `mem_wr`; `miso` stays 0.
- Abort: 02,20, then 5 bits of data, then `cs_n` high → no `mem_wr`. The next frame works normally.
- `rst` asserted during a write data byte → outputs return to reset values; no write. A following full frame 02,30,3C writes 8'h30=3C.
- Back-to-back frames with `cs_n` high for 4 clk cycles → both frames decoded correctly; `busy` toggles accordingly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and command codes for the SPI memory front-end.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR_ADDR,
        RD_ADDR,
        WR_DATA,
        RD_DATA,
        IGNORE
    } spi_state_t;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;

endpackage

// File: rtl/spi_sync_edge.sv
// One-bit multi-flop synchronizer with registered rise/fall pulses.
// level appears STAGES cycles after the input; rise/fall one cycle after level.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            prev <= sync[STAGES-1];
            rise <= sync[STAGES-1] & ~prev;
            fall <= ~sync[STAGES-1] & prev;
        end
    end

    assign level = sync[STAGES-1];

endmodule

// File: rtl/spi_mem_ctrl.sv
// SPI mode-0 slave sequencing a 256x8 memory: CMD, ADDR, then burst data bytes.
// Write strobe one cycle after a data byte completes; reads reload TX one cycle after each address update.
module spi_mem_ctrl
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    output logic       mem_wr,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_din,
    input  logic [7:0] mem_dout,
    output logic       busy,
    output logic       err
);

    spi_state_t             state;
    logic [2:0]             bit_cnt;
    logic [6:0]             rx;
    logic [7:0]             tx;
    logic                   tx_load;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_level, sclk_rise, sclk_fall;
    logic                   cs_level, cs_rise, cs_fall;
    logic                   mosi_s;
    logic [7:0]             rx_byte;
    logic                   byte_done;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (sclk),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // cs_n synchronizer resets low, so a reset taken mid-frame never sees a
    // falling edge until cs_n has genuinely gone high and low again.
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (cs_n),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_sync <= '0;
        end else begin
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign rx_byte   = {rx, mosi_s};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);
    assign miso      = (state == RD_DATA) && tx[7];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            rx       <= 7'd0;
            tx       <= 8'd0;
            tx_load  <= 1'b0;
            mem_wr   <= 1'b0;
            mem_addr <= 8'd0;
            mem_din  <= 8'd0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            mem_wr  <= 1'b0;
            err     <= 1'b0;
            tx_load <= 1'b0;
            if (mem_wr) begin
                mem_addr <= mem_addr + 8'd1;
            end
            if (tx_load) begin
                tx <= mem_dout;
            end

            if (cs_level || cs_rise) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else if (state == IDLE) begin
                // Mode 0: SCLK idles low when a frame opens.
                if (cs_fall && !sclk_level) begin
                    state   <= CMD;
                    busy    <= 1'b1;
                    bit_cnt <= 3'd0;
                    rx      <= 7'd0;
                    tx      <= 8'd0;
                end
            end else begin
                if (sclk_rise) begin
                    rx      <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end
                // No shift on the falling edge that closes a byte: that bit slot is the reload.
                if ((state == RD_DATA) && sclk_fall && (bit_cnt != 3'd0)) begin
                    tx <= {tx[6:0], 1'b0};
                end
                if (byte_done) begin
                    case (state)
                        CMD: begin
                            if (rx_byte == CMD_WRITE) begin
                                state <= WR_ADDR;
                            end else if (rx_byte == CMD_READ) begin
                                state <= RD_ADDR;
                            end else begin
                                state <= IGNORE;
                                err   <= 1'b1;
                            end
                        end
                        WR_ADDR: begin
                            mem_addr <= rx_byte;
                            state    <= WR_DATA;
                        end
                        RD_ADDR: begin
                            mem_addr <= rx_byte;
                            state    <= RD_DATA;
                            tx_load  <= 1'b1;
                        end
                        WR_DATA: begin
                            mem_din <= rx_byte;
                            mem_wr  <= 1'b1;
                        end
                        RD_DATA: begin
                            mem_addr <= mem_addr + 8'd1;
                            tx_load  <= 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule
